sr_latch_checker: RTL and testbench

Synthesizable on-chip checker for the SR latch, the observing end of the latch stimulus interface.
- Samples the s/r stimulus and the latch's q/qbar every clock.
- Runs a cycle-based golden model of a NOR-style SR latch and compares the latch outputs against it once a settle window has passed.
- Counts mismatches, forbidden-input occurrences and completed checks, so latch self-test runs in hardware without a simulator monitor.

---
 rtl/sr_latch_checker.sv | 191 +++++++++++++++++++
 tb/tb_sr_latch_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sr_latch_checker.sv
// On-chip checker for a NOR-style SR latch: a cycle-based golden model whose
// expectation is compared against q/qbar once the inputs have been stable for a settle window.
module sr_latch_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qbar,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] forb_cnt,
    output logic [CNT_W-1:0] check_cnt,
    output logic [1:0]       state
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] RELOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam int N_CNT = 3;
    localparam int CNT_ERR  = 0;
    localparam int CNT_FORB = 1;
    localparam int CNT_CHK  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CHECK   = 2'd2,
        UNKNOWN = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [SC_W-1:0]        settle_reg, settle_next;
    logic                   s_d_reg, r_d_reg;
    logic                   exp_q_reg, exp_q_next;
    logic                   exp_valid_reg, exp_valid_next;
    logic                   exp_forb_reg, exp_forb_next;
    logic                   err_reg, err_next;
    logic [CNT_W-1:0]       cnt_reg [N_CNT];
    logic [N_CNT-1:0]       cnt_inc;

    logic                   chg;
    logic                   model_load;
    logic                   compare;
    logic                   exp_qbar;
    logic                   mismatch;

    assign chg = ({s, r} != {s_d_reg, r_d_reg});

    // When both inputs are asserted a NOR latch drives both outputs low.
    assign exp_qbar = exp_forb_reg ? 1'b0 : ~exp_q_reg;
    assign mismatch = compare && ({q, qbar} != {exp_q_reg, exp_qbar});

    always_comb begin
        state_next  = state_reg;
        settle_next = settle_reg;
        model_load  = 1'b0;
        compare     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next  = SETTLE;
                    settle_next = RELOAD;
                    model_load  = 1'b1;
                end
            end
            SETTLE: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (chg) begin
                    settle_next = RELOAD;
                    model_load  = 1'b1;
                end else if (settle_reg == '0) begin
                    state_next = exp_valid_reg ? CHECK : UNKNOWN;
                end else begin
                    settle_next = settle_reg - 1'b1;
                end
            end
            CHECK: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (chg) begin
                    state_next  = SETTLE;
                    settle_next = RELOAD;
                    model_load  = 1'b1;
                end else begin
                    compare = 1'b1;
                end
            end
            UNKNOWN: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (chg) begin
                    state_next  = SETTLE;
                    settle_next = RELOAD;
                    model_load  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Golden latch model, evaluated from the current inputs and the previous sample.
    always_comb begin
        exp_q_next     = exp_q_reg;
        exp_valid_next = exp_valid_reg;
        exp_forb_next  = exp_forb_reg;
        if (model_load) begin
            case ({s, r})
                2'b10: begin
                    exp_q_next     = 1'b1;
                    exp_valid_next = 1'b1;
                    exp_forb_next  = 1'b0;
                end
                2'b01: begin
                    exp_q_next     = 1'b0;
                    exp_valid_next = 1'b1;
                    exp_forb_next  = 1'b0;
                end
                2'b11: begin
                    exp_q_next     = 1'b0;
                    exp_valid_next = 1'b1;
                    exp_forb_next  = 1'b1;
                end
                default: begin
                    // Releasing both inputs together is a race; the resolved state is unknowable.
                    if ({s_d_reg, r_d_reg} == 2'b11) begin
                        exp_valid_next = 1'b0;
                    end
                    exp_forb_next = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_inc           = '0;
        cnt_inc[CNT_ERR]  = mismatch;
        cnt_inc[CNT_FORB] = model_load && s && r;
        cnt_inc[CNT_CHK]  = compare;
        err_next          = mismatch;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            settle_reg    <= '0;
            s_d_reg       <= 1'b0;
            r_d_reg       <= 1'b0;
            exp_q_reg     <= 1'b0;
            exp_valid_reg <= 1'b0;
            exp_forb_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            settle_reg    <= settle_next;
            s_d_reg       <= s;
            r_d_reg       <= r;
            exp_q_reg     <= exp_q_next;
            exp_valid_reg <= exp_valid_next;
            exp_forb_reg  <= exp_forb_next;
            err_reg       <= err_next;
        end
    end

    // Saturating counters; a clear takes priority over a coincident increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CNT; i++) begin
            if (!rst_n || clr_cnt) begin
                cnt_reg[i] <= '0;
            end else if (cnt_inc[i] && (cnt_reg[i] != {CNT_W{1'b1}})) begin
                cnt_reg[i] <= cnt_reg[i] + 1'b1;
            end
        end
    end

    assign exp_q     = exp_q_reg;
    assign exp_valid = exp_valid_reg;
    assign err       = err_reg;
    assign err_cnt   = cnt_reg[CNT_ERR];
    assign forb_cnt  = cnt_reg[CNT_FORB];
    assign check_cnt = cnt_reg[CNT_CHK];
    assign state     = state_reg;

endmodule

// File: tb/tb_sr_latch_checker.sv
// Directed bench for sr_latch_checker: a behavioural age-based model queues the
// expected outputs for every driven cycle; they are popped and checked after the edge.
module tb_sr_latch_checker;

    localparam int SC = 2;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, en, clr_cnt, s, r, q, qbar;
    logic          exp_q, exp_valid, err;
    logic [CW-1:0] err_cnt, forb_cnt, check_cnt;
    logic [1:0]    state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] st;
        logic       eq;
        logic       ev;
        logic       er;
        int         ec;
        int         fc;
        int         cc;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    logic m_active, m_q, m_valid, m_err, m_sd, m_rd;
    logic [1:0] m_lastin;
    logic [1:0] m_state;
    int   m_age, m_ec, m_fc, m_cc;

    sr_latch_checker #(.SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .s(s), .r(r), .q(q), .qbar(qbar),
        .exp_q(exp_q), .exp_valid(exp_valid), .err(err),
        .err_cnt(err_cnt), .forb_cnt(forb_cnt), .check_cnt(check_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_q = 0; m_valid = 0; m_err = 0; m_sd = 0; m_rd = 0;
        m_lastin = 2'b00; m_state = 0; m_age = 0; m_ec = 0; m_fc = 0; m_cc = 0;
    endtask

    task automatic step(input logic rn, input logic en_i, input logic clr_i,
                        input logic s_i, input logic r_i, input logic q_i, input logic qb_i);
        exp_t e;
        logic c, cmp, mis;
        logic [1:0] want;
        rst_n = rn; en = en_i; clr_cnt = clr_i; s = s_i; r = r_i; q = q_i; qbar = qb_i;
        if (!rn) begin
            model_reset();
        end else begin
            c    = ({s_i, r_i} != {m_sd, m_rd});
            cmp  = (m_state == 2) && en_i && !c;
            want = (m_lastin == 2'b11) ? 2'b00 : {m_q, ~m_q};
            mis  = cmp && ({q_i, qb_i} != want);
            m_err = mis;
            if (!en_i) begin
                m_active = 0;
            end else if (!m_active || c) begin
                m_active = 1;
                m_age = 0;
                if ({s_i, r_i} == 2'b11) begin
                    m_q = 0; m_valid = 1; m_lastin = 2'b11;
                    m_fc = (m_fc < SAT) ? m_fc + 1 : m_fc;
                end else if ({s_i, r_i} == 2'b10) begin
                    m_q = 1; m_valid = 1; m_lastin = 2'b10;
                end else if ({s_i, r_i} == 2'b01) begin
                    m_q = 0; m_valid = 1; m_lastin = 2'b01;
                end else begin
                    if ({m_sd, m_rd} == 2'b11) m_valid = 0;
                    m_lastin = 2'b00;
                end
            end else if (m_age < SC) begin
                m_age++;
            end
            if (!m_active)       m_state = 0;
            else if (m_age < SC) m_state = 1;
            else                 m_state = m_valid ? 2'd2 : 2'd3;
            if (mis) m_ec = (m_ec < SAT) ? m_ec + 1 : m_ec;
            if (cmp) m_cc = (m_cc < SAT) ? m_cc + 1 : m_cc;
            if (clr_i) begin
                m_ec = 0; m_fc = 0; m_cc = 0;
            end
            m_sd = s_i; m_rd = r_i;
        end
        e.st = m_state; e.eq = m_q; e.ev = m_valid; e.er = m_err;
        e.ec = m_ec; e.fc = m_fc; e.cc = m_cc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        $display("cycle rst_n=%0b en=%0b clr=%0b sr=%0b%0b qqb=%0b%0b -> state=%0d exp_q=%0b exp_valid=%0b err=%0b cnt=%0d/%0d/%0d",
                 rn, en_i, clr_i, s_i, r_i, q_i, qb_i, state, exp_q, exp_valid, err,
                 err_cnt, forb_cnt, check_cnt);
        chk("state", int'(state), int'(e.st));
        chk("exp_q", int'(exp_q), int'(e.eq));
        chk("exp_valid", int'(exp_valid), int'(e.ev));
        chk("err", int'(err), int'(e.er));
        chk("err_cnt", int'(err_cnt), e.ec);
        chk("forb_cnt", int'(forb_cnt), e.fc);
        chk("check_cnt", int'(check_cnt), e.cc);
    endtask

    initial begin
        int saved_cc;
        model_reset();
        rst_n = 0; en = 0; clr_cnt = 0; s = 0; r = 0; q = 0; qbar = 0;

        // reset with random stimulus
        repeat (2) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        1'($urandom), 1'($urandom));
        chk("tp1_state", int'(state), 0);
        chk("tp1_check_cnt", int'(check_cnt), 0);

        // hold 01 with a correct latch
        repeat (10) step(1, 1, 0, 0, 1, 0, 1);
        chk("tp2_check_cnt", int'(check_cnt), 7);
        chk("tp2_exp_q", int'(exp_q), 0);

        // set with a stuck latch
        repeat (6) step(1, 1, 0, 1, 0, 0, 1);
        chk("tp3_err_cnt", int'(err_cnt), 3);
        chk("tp3_exp_q", int'(exp_q), 1);

        // forbidden input, race release, then recovery
        repeat (4) step(1, 1, 0, 1, 1, 0, 0);
        chk("tp4_forb_cnt", int'(forb_cnt), 1);
        repeat (5) step(1, 1, 0, 0, 0, 0, 0);
        chk("tp4_unknown_state", int'(state), 3);
        chk("tp4_unknown_valid", int'(exp_valid), 0);
        chk("tp4_err_cnt_held", int'(err_cnt), 3);
        repeat (5) step(1, 1, 0, 1, 0, 1, 0);
        chk("tp4_recover_state", int'(state), 2);
        chk("tp4_recover_q", int'(exp_q), 1);

        // saturation and clear priority
        step(1, 1, 1, 1, 0, 1, 0);
        repeat (20) step(1, 1, 0, 1, 0, 0, 1);
        chk("tp5_err_sat", int'(err_cnt), SAT);
        step(1, 1, 1, 1, 0, 0, 1);
        chk("tp5_err_clr", int'(err_cnt), 0);

        // disable returns to idle
        repeat (2) step(1, 0, 0, 1, 0, 1, 0);
        chk("en_off_state", int'(state), 0);

        // continuous toggling never leaves settle
        saved_cc = int'(check_cnt);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1'(i % 2), 0, 1'(i % 2), 1'((i + 1) % 2));
        chk("tp6_toggle_state", int'(state), 1);
        chk("tp6_toggle_cc", int'(check_cnt), saved_cc);
        repeat (4) step(1, 1, 0, 1, 0, 1, 0);
        chk("tp6_in_check", int'(state), 2);
        step(0, 1, 0, 1, 0, 0, 1);
        chk("tp6_rst_state", int'(state), 0);
        chk("tp6_rst_valid", int'(exp_valid), 0);
        step(1, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
